// File: rtl/adc_acq_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_acq_sequencer_if
// Bundles the signals between the ADC acquisition sequencer, its requester
// (SPGD update core) and the ADC front end. The clock and reset stay as plain
// ports on the sequencer.
//
//   enable        requester -> seq   block enable; low forces STOPPED
//   meas_req      requester -> seq   measurement request (sampled in IDLE)
//   busy          seq -> requester   high except in STOPPED and IDLE
//   metric        seq -> requester   averaged result
//   metric_valid  seq -> requester   result available, held until accepted
//   metric_ready  requester -> seq   result accepted
//   timeout_err   seq -> requester   sticky conversion-timeout flag
//   err_clr       requester -> seq   clears timeout_err
//   adc_start     seq -> ADC         one-cycle conversion start pulse
//   adc_done      ADC -> seq         conversion complete, adc_data valid
//   adc_data      ADC -> seq         conversion result
//   reg_write     seq -> ADC         one-cycle strobe per accepted sample
//   reg_rst       seq -> ADC         result-register reset (STOPPED)
//   adc_rst       seq -> ADC         ADC reset
//
// The master modport is the sequencer view; slave is the environment view.
// ---------------------------------------------------------------------------
interface adc_acq_sequencer_if #(
  parameter int DATA_W = 14
);
  logic              enable;
  logic              meas_req;
  logic              busy;
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              reg_write;
  logic              reg_rst;
  logic              adc_rst;
  logic [DATA_W-1:0] metric;
  logic              metric_valid;
  logic              metric_ready;
  logic              timeout_err;
  logic              err_clr;

  modport master (
    input  enable, meas_req, adc_done, adc_data, metric_ready, err_clr,
    output busy, adc_start, reg_write, reg_rst, adc_rst, metric,
           metric_valid, timeout_err
  );

  modport slave (
    output enable, meas_req, adc_done, adc_data, metric_ready, err_clr,
    input  busy, adc_start, reg_write, reg_rst, adc_rst, metric,
           metric_valid, timeout_err
  );
endinterface

// File: rtl/adc_acq_sequencer.sv
// ---------------------------------------------------------------------------
// adc_acq_sequencer
// Runs one SPGD metric measurement: waits SETTLE_CYC cycles after a request,
// takes 2^AVG_LOG2 ADC conversions (each guarded by a TIMEOUT_CYC watchdog),
// and presents the truncated average on a valid/ready handshake.
//
// Ports:
//   adc_clk  clock, all logic on its rising edge
//   rst_n    synchronous active-low reset
//   bus      adc_acq_sequencer_if.master (request/result handshake, ADC
//            strobes, error flag)
// ---------------------------------------------------------------------------
module adc_acq_sequencer #(
  parameter int DATA_W      = 14,
  parameter int AVG_LOG2    = 3,
  parameter int SETTLE_CYC  = 100,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input logic                  adc_clk,
  input logic                  rst_n,
  adc_acq_sequencer_if.master  bus
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int NSAMP  = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SCNT_W-1:0] SCNT_FULL    = SCNT_W'(NSAMP);

  typedef enum logic [3:0] {
    ST_STOPPED,
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_RECOVER,
    ST_DONE,
    ST_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [ACC_W-1:0]    acc_q,   acc_d;
  logic [SCNT_W-1:0]   scnt_q,  scnt_d;
  logic                err_q,   err_d;

  // Truncating average: dropping the AVG_LOG2 LSBs divides by the sample count.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:AVG_LOG2];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    err_d   = err_q;

    if (bus.err_clr) err_d = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        acc_d  = '0;
        scnt_d = '0;
        cnt_d  = '0;
        if (bus.enable) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.meas_req) begin
          acc_d   = '0;
          scnt_d  = '0;
          cnt_d   = '0;
          state_d = (SETTLE_CYC == 0) ? ST_START : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_START;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // adc_done takes priority over an expiring timeout in the same cycle.
        if (bus.adc_done) begin
          acc_d   = acc_q + ACC_W'(bus.adc_data);
          state_d = ST_CAPTURE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        scnt_d  = scnt_q + SCNT_W'(1);
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        state_d = (scnt_q == SCNT_FULL) ? ST_DONE : ST_START;
      end
      ST_DONE: begin
        if (bus.metric_ready) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        // Set overrides a simultaneous err_clr.
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_STOPPED;
    endcase

    // Disable aborts any measurement in progress; the error flag survives.
    if (!bus.enable) begin
      state_d = ST_STOPPED;
      acc_d   = '0;
      scnt_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state_q <= ST_STOPPED;
      cnt_q   <= '0;
      acc_q   <= '0;
      scnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign bus.busy         = !(state_q inside {ST_STOPPED, ST_IDLE});
  assign bus.adc_start    = (state_q == ST_START);
  assign bus.reg_write    = (state_q == ST_CAPTURE);
  assign bus.reg_rst      = (state_q == ST_STOPPED);
  assign bus.adc_rst      = (state_q inside {ST_STOPPED, ST_RECOVER, ST_ABORT});
  assign bus.metric_valid = (state_q == ST_DONE);
  assign bus.metric       = avg_trunc(acc_q);
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
module tb_adc_acq_sequencer;
  localparam int DW  = 14;
  localparam int SET = 4;
  localparam int TO  = 10;

  logic adc_clk = 1'b0;
  logic rst_n;
  always #5 adc_clk = ~adc_clk;

  adc_acq_sequencer_if #(.DATA_W(DW)) ifa ();
  adc_acq_sequencer_if #(.DATA_W(DW)) ifb ();

  adc_acq_sequencer #(.DATA_W(DW), .AVG_LOG2(2), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO), .CNT_W(16))
    dut_a (.adc_clk(adc_clk), .rst_n(rst_n), .bus(ifa.master));

  adc_acq_sequencer #(.DATA_W(DW), .AVG_LOG2(3), .SETTLE_CYC(0), .TIMEOUT_CYC(TO), .CNT_W(16))
    dut_b (.adc_clk(adc_clk), .rst_n(rst_n), .bus(ifb.master));

  int n_tests = 0;
  int n_fail  = 0;

  // ADC models: answer each adc_start 'lat' cycles later (lat=0: never).
  logic [7:0][DW-1:0] ma_samp, mb_samp;
  int ma_lat, mb_lat;
  int ma_cd, ma_idx, mb_cd, mb_idx;

  initial begin
    ifa.adc_done = 1'b0; ifa.adc_data = '0; ma_cd = 0; ma_idx = 0;
    forever begin
      @(posedge adc_clk); #1;
      ifa.adc_done = 1'b0;
      if (ifa.busy === 1'b0) begin
        ma_cd = 0; ma_idx = 0;
      end else if (ma_cd > 0) begin
        ma_cd--;
        if (ma_cd == 0) begin
          ifa.adc_done = 1'b1;
          ifa.adc_data = ma_samp[ma_idx[2:0]];
          ma_idx++;
        end
      end
      if (ifa.adc_start === 1'b1 && ma_lat > 0) ma_cd = ma_lat;
    end
  end

  initial begin
    ifb.adc_done = 1'b0; ifb.adc_data = '0; mb_cd = 0; mb_idx = 0;
    forever begin
      @(posedge adc_clk); #1;
      ifb.adc_done = 1'b0;
      if (ifb.busy === 1'b0) begin
        mb_cd = 0; mb_idx = 0;
      end else if (mb_cd > 0) begin
        mb_cd--;
        if (mb_cd == 0) begin
          ifb.adc_done = 1'b1;
          ifb.adc_data = mb_samp[mb_idx[2:0]];
          mb_idx++;
        end
      end
      if (ifb.adc_start === 1'b1 && mb_lat > 0) mb_cd = mb_lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Per-measurement observation of dut_a.
  int cyc, n_start, n_wr, n_arst, first_start, last_start, last_arst, bad_seq;
  bit prev_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk); #1;
    cyc++;
    if (ifa.adc_start === 1'b1) begin
      n_start++;
      last_start = cyc;
      if (first_start < 0) first_start = cyc;
    end
    if (prev_wr && ifa.adc_rst !== 1'b1) bad_seq++;
    prev_wr = (ifa.reg_write === 1'b1);
    if (ifa.reg_write === 1'b1) n_wr++;
    if (ifa.adc_rst === 1'b1 && ifa.busy === 1'b1) begin
      n_arst++;
      last_arst = cyc;
    end
  endtask

  task automatic clear_obs();
    cyc = 0; n_start = 0; n_wr = 0; n_arst = 0; first_start = -1;
    last_start = 0; last_arst = 0; bad_seq = 0; prev_wr = 1'b0;
  endtask

  // One measurement on dut_a starting from IDLE; meas_req issued at cycle 0.
  task automatic measure(input logic [3:0][DW-1:0] s, input int lat, input int hold,
                         input bit poke, output bit got_valid, output logic [DW-1:0] m);
    int budget;
    int stable_bad;
    ma_samp[3:0] = s;
    ma_lat = lat;
    clear_obs();
    ifa.meas_req = 1'b1;
    step();
    ifa.meas_req = 1'b0;
    budget = 400;
    while (ifa.busy === 1'b1 && ifa.metric_valid !== 1'b1 && budget > 0) begin
      ifa.meas_req = poke && (cyc == 2);
      step();
      budget--;
    end
    ifa.meas_req = 1'b0;
    check("meas_budget", 32'(budget > 0), 32'd1);
    got_valid = (ifa.metric_valid === 1'b1);
    m = ifa.metric;
    if (got_valid) begin
      stable_bad = 0;
      for (int i = 0; i < hold; i++) begin
        ifa.meas_req = poke && (i == 0);
        step();
        if (ifa.metric_valid !== 1'b1 || ifa.metric !== m) stable_bad++;
      end
      if (hold > 0) check("metric_hold_stable", 32'(stable_bad), 32'd0);
      ifa.metric_ready = 1'b1;
      ifa.meas_req = poke;
      step();
      ifa.metric_ready = 1'b0;
      ifa.meas_req = 1'b0;
      check("valid_drop_after_hs", 32'(ifa.metric_valid), 32'd0);
      check("idle_after_hs", 32'(ifa.busy), 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0][DW-1:0] s;
    int                 lat;
    logic [DW-1:0]      em;
    bit                 ab;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int lat, input int em, input bit ab);
    vec_t v;
    v.s[0] = DW'(a); v.s[1] = DW'(b); v.s[2] = DW'(c); v.s[3] = DW'(d);
    v.lat = lat; v.em = DW'(em); v.ab = ab;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    bit got;
    logic [DW-1:0] m;
    int budget, nb, idle_bad;

    tbl[0] = mk(100, 101, 102, 103, 3, 101, 1'b0);
    tbl[1] = mk(0, 0, 0, 0, 1, 0, 1'b0);
    tbl[2] = mk(16383, 16383, 16383, 16383, 2, 16383, 1'b0);
    tbl[3] = mk(1, 2, 3, 5, 5, 2, 1'b0);
    tbl[4] = mk(1000, 2000, 3000, 4000, TO, 2500, 1'b0);   // done in final WAIT cycle
    tbl[5] = mk(7, 7, 7, 7, TO + 1, 0, 1'b1);              // one cycle too late
    tbl[6] = mk(16383, 0, 16383, 0, 4, 8191, 1'b0);

    rst_n = 1'b0;
    ifa.enable = 1'b0; ifa.meas_req = 1'b0; ifa.metric_ready = 1'b0; ifa.err_clr = 1'b0;
    ifb.enable = 1'b0; ifb.meas_req = 1'b0; ifb.metric_ready = 1'b0; ifb.err_clr = 1'b0;
    ma_lat = 0; mb_lat = 0; ma_samp = '0; mb_samp = '0;
    clear_obs();
    repeat (3) step();

    // Reset state
    check("rst_busy",         32'(ifa.busy), 32'd0);
    check("rst_reg_rst",      32'(ifa.reg_rst), 32'd1);
    check("rst_adc_rst",      32'(ifa.adc_rst), 32'd1);
    check("rst_adc_start",    32'(ifa.adc_start), 32'd0);
    check("rst_reg_write",    32'(ifa.reg_write), 32'd0);
    check("rst_metric_valid", 32'(ifa.metric_valid), 32'd0);
    check("rst_metric",       32'(ifa.metric), 32'd0);
    check("rst_timeout_err",  32'(ifa.timeout_err), 32'd0);

    rst_n = 1'b1; ifa.enable = 1'b1; ifb.enable = 1'b1;
    step();
    check("idle_reg_rst", 32'(ifa.reg_rst), 32'd0);
    check("idle_adc_rst", 32'(ifa.adc_rst), 32'd0);
    check("idle_busy",    32'(ifa.busy), 32'd0);

    // Table-driven measurements
    for (int k = 0; k < 7; k++) begin
      ifa.err_clr = 1'b1;
      step();
      ifa.err_clr = 1'b0;
      check("err_clr_before", 32'(ifa.timeout_err), 32'd0);
      measure(tbl[k].s, tbl[k].lat, 0, 1'b0, got, m);
      check("first_start_cycle", 32'(first_start), 32'(SET + 1));
      check("metric_valid_seen", 32'(got), 32'(!tbl[k].ab));
      check("timeout_err",       32'(ifa.timeout_err), 32'(tbl[k].ab));
      check("reg_write_count",   32'(n_wr), tbl[k].ab ? 32'd0 : 32'd4);
      check("adc_rst_count",     32'(n_arst), tbl[k].ab ? 32'd1 : 32'd4);
      check("adc_start_count",   32'(n_start), tbl[k].ab ? 32'd1 : 32'd4);
      check("write_then_rst",    32'(bad_seq), 32'd0);
      if (tbl[k].ab) check("abort_after_wait", 32'(last_arst - last_start), 32'(TO + 1));
      else           check("metric_value", 32'(m), 32'(tbl[k].em));
    end

    // meas_req during SETTLE, DONE and handshake is dropped; ready held low 20 cycles
    measure(tbl[0].s, 3, 20, 1'b1, got, m);
    check("poke_valid",  32'(got), 32'd1);
    check("poke_metric", 32'(m), 32'd101);
    idle_bad = 0;
    repeat (30) begin
      step();
      if (ifa.busy !== 1'b0) idle_bad++;
    end
    check("poke_stays_idle", 32'(idle_bad), 32'd0);
    check("poke_one_meas",   32'(n_start), 32'd4);

    // ABORT with err_clr in the same cycle: the set wins
    ifa.err_clr = 1'b1;
    step();
    ifa.err_clr = 1'b0;
    check("err_clr_pre_abort", 32'(ifa.timeout_err), 32'd0);
    ma_lat = 0;
    clear_obs();
    ifa.meas_req = 1'b1;
    step();
    ifa.meas_req = 1'b0;
    budget = 100;
    while (!(ifa.busy === 1'b1 && ifa.adc_rst === 1'b1) && budget > 0) begin
      step();
      budget--;
    end
    check("abort_reached", 32'(budget > 0), 32'd1);
    ifa.err_clr = 1'b1;
    step();
    ifa.err_clr = 1'b0;
    check("abort_set_wins",    32'(ifa.timeout_err), 32'd1);
    check("abort_to_idle",     32'(ifa.busy), 32'd0);
    check("abort_no_valid",    32'(ifa.metric_valid), 32'd0);

    // enable dropped during WAIT of the 2nd sample
    ma_samp = {8{DW'(5000)}};
    ma_lat = 5;
    clear_obs();
    ifa.meas_req = 1'b1;
    step();
    ifa.meas_req = 1'b0;
    budget = 100;
    while (n_start < 2 && budget > 0) begin
      step();
      budget--;
    end
    check("second_start_seen", 32'(budget > 0), 32'd1);
    step();
    step();
    ifa.enable = 1'b0;
    step();
    check("dis_busy",        32'(ifa.busy), 32'd0);
    check("dis_reg_rst",     32'(ifa.reg_rst), 32'd1);
    check("dis_adc_rst",     32'(ifa.adc_rst), 32'd1);
    check("dis_valid",       32'(ifa.metric_valid), 32'd0);
    check("dis_err_kept",    32'(ifa.timeout_err), 32'd1);
    ifa.enable = 1'b1;
    step();
    check("reen_reg_rst", 32'(ifa.reg_rst), 32'd0);
    measure(mk(40, 41, 42, 43, 3, 41, 1'b0).s, 3, 0, 1'b0, got, m);
    check("reen_valid",  32'(got), 32'd1);
    check("reen_metric", 32'(m), 32'd41);
    check("reen_writes", 32'(n_wr), 32'd4);

    ifa.err_clr = 1'b1;
    step();
    ifa.err_clr = 1'b0;
    check("err_clr_after", 32'(ifa.timeout_err), 32'd0);

    // Full-scale, AVG_LOG2=3, SETTLE_CYC=0 on dut_b
    mb_samp = {8{DW'(16383)}};
    mb_lat = 2;
    ifb.meas_req = 1'b1;
    step();
    ifb.meas_req = 1'b0;
    check("b_start_cycle1", 32'(ifb.adc_start), 32'd1);
    nb = 0;
    budget = 400;
    while (ifb.metric_valid !== 1'b1 && budget > 0) begin
      step();
      budget--;
      if (ifb.reg_write === 1'b1) nb++;
    end
    check("b_budget",      32'(budget > 0), 32'd1);
    check("b_metric_full", 32'(ifb.metric), 32'd16383);
    check("b_writes",      32'(nb), 32'd8);
    check("b_no_err",      32'(ifb.timeout_err), 32'd0);
    ifb.metric_ready = 1'b1;
    step();
    ifb.metric_ready = 1'b0;
    check("b_valid_drop", 32'(ifb.metric_valid), 32'd0);
    check("b_idle",       32'(ifb.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
- Sequences the ADC for one SPGD metric measurement: waits a settle time after each perturbation, issues 2^AVG_LOG2 conversions, and averages the results.
- Drives the ADC start, register-write and reset strobes, and guards every conversion with a timeout.
- Sits between the SPGD update core (meas_req / metric handshake) and the ADC interface, in the adc_clk domain.

Parameters:
DATA_W, 14, ADC sample width (unsigned)
AVG_LOG2, 3, log2 of the number of samples averaged per measurement (0..8)
SETTLE_CYC, 100, adc_clk cycles waited after meas_req before the first conversion (0 = no settle)
TIMEOUT_CYC, 1000, maximum WAIT cycles for adc_done per conversion (at least 1)
CNT_W, 16, width of the shared settle/timeout counter (must hold max(SETTLE_CYC, TIMEOUT_CYC))

Ports:
adc_clk  in  1  clock; all logic on its rising edge
rst_n  in  1  synchronous reset, active-low
enable  in  1  block enable; low forces STOPPED
meas_req  in  1  measurement request; sampled only in IDLE
busy  out  1  high in every state except STOPPED and IDLE
adc_start  out  1  one-cycle conversion start pulse
adc_done  in  1  conversion complete; adc_data is valid in the same cycle
adc_data  in  DATA_W  conversion result
reg_write  out  1  one-cycle strobe after each accepted sample
reg_rst  out  1  result-register reset; high in STOPPED
adc_rst  out  1  ADC reset; high in STOPPED and RECOVER, and for the single ABORT cycle
metric  out  DATA_W  averaged result; stable while metric_valid is high
metric_valid  out  1  result available; held until accepted
metric_ready  in  1  consumer accepts the result
timeout_err  out  1  sticky conversion-timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- States: STOPPED, IDLE, SETTLE, START, WAIT, CAPTURE, RECOVER, DONE, ABORT.
- Reset (rst_n=0 at a clock edge):
  - state=STOPPED; reg_rst=1, adc_rst=1.
  - All other outputs 0; accumulator, sample count and counter cleared; timeout_err=0.
- enable=0: next state is STOPPED from any state, even mid-measurement.
  - The accumulator is discarded and metric_valid drops; timeout_err is kept.
- STOPPED -> IDLE when enable=1.
- IDLE:
  - meas_req=1 -> SETTLE with the counter cleared; if SETTLE_CYC=0, go directly to START.
  - Accumulator and sample count are cleared on exit from IDLE.
- SETTLE: counts SETTLE_CYC cycles, then -> START.
  - meas_req at cycle 0 gives adc_start at cycle SETTLE_CYC+1.
- START: adc_start=1 for exactly one cycle; counter cleared; -> WAIT.
- WAIT:
  - adc_done=1: acc += adc_data (zero-extended to DATA_W+AVG_LOG2 bits, which cannot overflow); -> CAPTURE.
  - Otherwise counter increments; when it reaches TIMEOUT_CYC-1 with adc_done=0, -> ABORT.
  - If adc_done and timeout occur in the same cycle, adc_done wins.
- adc_done outside WAIT is ignored.
- CAPTURE: reg_write=1 for one cycle; sample count increments; -> RECOVER.
- RECOVER: adc_rst=1 for one cycle.
  - Sample count == 2^AVG_LOG2 -> DONE; otherwise -> START.
- DONE:
  - metric = acc[DATA_W+AVG_LOG2-1:AVG_LOG2] (truncating average); metric_valid=1.
  - metric_valid=1 and metric_ready=1 -> IDLE next cycle; metric_valid deasserts in that cycle.
  - meas_req is ignored in DONE and in the handshake cycle; the requester re-issues it in IDLE.
- ABORT: timeout_err<=1 and adc_rst=1 for one cycle; -> IDLE with no metric produced.
- timeout_err: err_clr clears it. If a set (ABORT) and err_clr occur in the same cycle, the set wins.
- Conversion cadence: one conversion occupies START+WAIT+CAPTURE+RECOVER, i.e. at least 4 cycles, with at most one adc_start per conversion.
- meas_req outside IDLE is dropped; requests are not queued.

Test Plan:
- Reset, then enable=1, SETTLE_CYC=4, AVG_LOG2=2; meas_req pulse at cycle 0; ADC model answers each adc_start 3 cycles later with data 100, 101, 102, 103 -> first adc_start at cycle 5; four reg_write pulses, each followed by an adc_rst cycle; metric=101; metric_valid holds until metric_ready.
- Full-scale: DATA_W=14, AVG_LOG2=3, all samples 16383 -> metric=16383, no overflow.
- Timeout: TIMEOUT_CYC=10, ADC never answers -> ABORT after 10 WAIT cycles; timeout_err=1 with an adc_rst pulse; state IDLE; metric_valid never set; err_clr -> timeout_err=0.
- Boundary: adc_done arrives exactly in the final WAIT cycle -> sample is accepted and timeout_err stays 0. Separately, err_clr in the same cycle as an ABORT -> timeout_err=1.
- enable dropped during WAIT of the 2nd sample -> next cycle STOPPED with reg_rst=adc_rst=1 and busy=0; re-enable plus meas_req -> fresh 4-sample average unaffected by the partial data.
- meas_req pulsed during SETTLE and during DONE -> ignored, with exactly one measurement produced. metric_ready held at 0 for 20 cycles -> metric_valid and metric stay stable throughout.
